// File: rtl/shift_add_multiplier_pkg.sv
// Shared state encodings and helpers for the iterative shift-add multiplier.
package shift_add_multiplier_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t RUN  = 2'd1;
  localparam state_t DONE = 2'd2;

  // Sign-extends the low 'width' bits of value to 64 bits; callers truncate to their product width.
  function automatic logic [63:0] sext_to_width(input logic [63:0] value, input int unsigned width);
    logic signed [63:0] shifted;
    shifted = $signed(value << (64 - width));
    return $unsigned(shifted >>> (64 - width));
  endfunction

endpackage

// File: rtl/shift_add_multiplier.sv
// Iterative signed*unsigned shift-add multiplier with signed addend: product = multiplicand * multiplier + addend.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int unsigned mcand_width  = 16,
  parameter int unsigned mplier_width = 8,
  parameter int unsigned prod_width   = mcand_width + mplier_width
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [mcand_width-1:0]  multiplicand,
  input  logic [mplier_width-1:0] multiplier,
  input  logic [mcand_width-1:0]  addend,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [prod_width-1:0]   product,
  output logic                    busy
);

  localparam int unsigned count_width = $clog2(mplier_width + 1);
  localparam logic [count_width-1:0] last_step = count_width'(mplier_width - 1);

  state_t                  state;
  logic                    neg;
  logic [prod_width-1:0]   mag_shifted;
  logic [mplier_width-1:0] mplier_reg;
  logic [mcand_width-1:0]  addend_reg;
  logic [prod_width-1:0]   acc;
  logic [count_width-1:0]  count;

  logic [mcand_width-1:0]  magnitude;
  logic [prod_width-1:0]   acc_step;
  logic [prod_width-1:0]   addend_ext;
  logic [prod_width-1:0]   result;

  assign in_ready = (state == IDLE);
  assign busy     = (state == RUN) || (state == DONE);

  // Magnitude is kept unsigned so the most negative multiplicand maps to 2^(mcand_width-1) without overflow.
  always_comb begin
    magnitude  = multiplicand[mcand_width-1] ? -multiplicand : multiplicand;
    acc_step   = mplier_reg[0] ? acc + mag_shifted : acc;
    addend_ext = prod_width'(sext_to_width(64'(addend_reg), mcand_width));
    result     = (neg ? -acc_step : acc_step) + addend_ext;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      neg         <= 1'b0;
      mag_shifted <= '0;
      mplier_reg  <= '0;
      addend_reg  <= '0;
      acc         <= '0;
      count       <= '0;
      product     <= '0;
      out_valid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            neg         <= multiplicand[mcand_width-1];
            mag_shifted <= prod_width'(magnitude);
            mplier_reg  <= multiplier;
            addend_reg  <= addend;
            acc         <= '0;
            count       <= '0;
            state       <= RUN;
          end
        end
        RUN: begin
          acc         <= acc_step;
          mag_shifted <= mag_shifted << 1;
          mplier_reg  <= mplier_reg >> 1;
          count       <= count + count_width'(1);
          if (count == last_step) begin
            product   <= result;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products queued at accept, compared at output.
module tb_shift_add_multiplier;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic [15:0] addend = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [23:0] product;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;
  logic [23:0] exp_q[$];

  shift_add_multiplier #(
    .mcand_width (16),
    .mplier_width(8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .addend      (addend),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .product     (product),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [23:0] model(input logic [15:0] a, input logic [7:0] b, input logic [15:0] c);
    int p;
    p = int'($signed(a)) * int'(b) + int'($signed(c));
    return 24'(p);
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] c);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) begin
      tests_run++;
      tests_failed++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
    end
    multiplicand = a;
    multiplier   = b;
    addend       = c;
    in_valid     = 1'b1;
    step();
    in_valid = 1'b0;
    exp_q.push_back(model(a, b, c));
  endtask

  task automatic wait_out(output bit ok, output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      step();
      cycles++;
    end
    ok = out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b1;
    step();
    step();
    reset = 1'b0;
    in_valid = 1'b0;
    tests_run++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== 24'h0) begin
      tests_failed++;
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b busy=%0b product=%h required 1 0 0 000000",
               in_ready, out_valid, busy, product);
    end
  endtask

  task automatic test_roundtrip();
    bit ok;
    int lat;
    logic [23:0] exp;
    drive_op(16'd33, 8'd3, 16'd1);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || lat != 8) begin
      tests_failed++;
      $display("FAIL roundtrip_latency: got %0d cycles (valid=%0b) required 8", lat, ok);
    end
    tests_run++;
    if (product !== exp || exp !== 24'h000064) begin
      tests_failed++;
      $display("FAIL roundtrip_product: got %h required 000064", product);
    end
    consume();
  endtask

  task automatic test_signed_and_extremes();
    logic [15:0] a_tab[4] = '{16'hFFEF, 16'hFFEF, 16'h8000, 16'h7FFF};
    logic [7:0]  b_tab[4] = '{8'd1, 8'd2, 8'd255, 8'd255};
    logic [15:0] c_tab[4] = '{16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF};
    logic [23:0] r_tab[4] = '{24'hFFFFEF, 24'hFFFFDD, 24'h800000, 24'h7FFF00};
    for (int i = 0; i < 4; i++) begin
      bit ok;
      int lat;
      logic [23:0] exp;
      drive_op(a_tab[i], b_tab[i], c_tab[i]);
      wait_out(ok, lat);
      exp = exp_q.pop_front();
      tests_run++;
      if (!ok || product !== r_tab[i] || exp !== r_tab[i]) begin
        tests_failed++;
        $display("FAIL signed_extreme[%0d]: got %h (valid=%0b) required %h", i, product, ok, r_tab[i]);
      end
      consume();
    end
  endtask

  task automatic test_zero_cases();
    bit ok;
    int lat;
    logic [23:0] exp;
    drive_op(16'd1234, 8'd0, 16'hFF9C);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || lat != 8 || product !== exp) begin
      tests_failed++;
      $display("FAIL zero_multiplier: got %h after %0d cycles required %h after 8", product, lat, exp);
    end
    consume();
    drive_op(16'd0, 8'd77, 16'h8001);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || product !== 24'hFF8001) begin
      tests_failed++;
      $display("FAIL zero_multiplicand: got %h required FF8001", product);
    end
    consume();
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [23:0] exp;
    drive_op(16'd500, 8'd9, 16'hFFF6);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        multiplicand = 16'd7;
        multiplier   = 8'd7;
        addend       = 16'd7;
        in_valid     = 1'b1;
      end
      step();
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || product !== exp) begin
        tests_failed++;
        $display("FAIL backpressure_hold[%0d]: out_valid=%0b in_ready=%0b product=%h required 1 0 %h",
                 i, out_valid, in_ready, product, exp);
      end
    end
    consume();
    tests_run++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== exp) begin
      tests_failed++;
      $display("FAIL backpressure_release: out_valid=%0b in_ready=%0b product=%h required 0 1 %h",
               out_valid, in_ready, product, exp);
    end
    drive_op(16'hFFFE, 8'd100, 16'd3);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || product !== exp || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL back_to_back: got %h required %h (queue %0d)", product, exp, exp_q.size());
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    bit ok;
    int lat;
    logic [23:0] exp;
    drive_op(16'd999, 8'd99, 16'd9);
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    void'(exp_q.pop_back());
    tests_run++;
    if (out_valid !== 1'b0 || product !== 24'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_mid_run: out_valid=%0b product=%h in_ready=%0b busy=%0b required 0 000000 1 0",
               out_valid, product, in_ready, busy);
    end
    drive_op(16'd0, 8'd200, 16'd5);
    wait_out(ok, lat);
    exp = exp_q.pop_front();
    tests_run++;
    if (!ok || product !== 24'd5 || exp !== 24'd5) begin
      tests_failed++;
      $display("FAIL after_reset_op: got %h required 000005", product);
    end
    consume();
  endtask

  task automatic test_soak();
    for (int i = 0; i < 1000; i++) begin
      bit ok;
      int lat;
      int stall;
      logic [23:0] exp;
      logic [23:0] held;
      drive_op(16'($urandom), 8'($urandom), 16'($urandom));
      multiplicand = 16'($urandom);
      addend       = 16'($urandom);
      wait_out(ok, lat);
      stall = $urandom_range(0, 3);
      held = product;
      for (int s = 0; s < stall; s++) step();
      exp = exp_q.pop_front();
      tests_run++;
      if (!ok || product !== exp || product !== held) begin
        tests_failed++;
        $display("FAIL soak[%0d]: got %h (valid=%0b) required %h", i, product, ok, exp);
      end
      consume();
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL soak_dup[%0d]: out_valid=%0b required 0", i, out_valid);
      end
    end
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL soak_queue: %0d leftover required 0", exp_q.size());
    end
  endtask

  initial begin
    step();
    test_reset();
    test_roundtrip();
    test_signed_and_extremes();
    test_zero_cases();
    test_backpressure();
    test_reset_mid_run();
    test_soak();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/shift_add_multiplier.md
Name: shift_add_multiplier

Overview:
Iterative shift-add multiplier that computes product = multiplicand * multiplier + addend.
- multiplicand and addend are signed; multiplier is unsigned.
- It is the inverse of the divider datapath: it reconstructs dividend = quotient * divisor + remainder. It is used for divider self-check and for scaling paths.
- One operand set is in flight at a time. Input and output use valid/ready handshakes.

Parameters:
mcand_width, 16, width of signed multiplicand and addend (two's complement)
mplier_width, 8, width of unsigned multiplier; equals RUN cycles per operation
prod_width, mcand_width + mplier_width, derived; width of signed product (do not override)

Ports:
clock  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  operand set presented
in_ready  out  1  block can accept operands
multiplicand  in  mcand_width  signed operand
multiplier  in  mplier_width  unsigned operand
addend  in  mcand_width  signed value added after multiply
out_valid  out  1  product valid and held stable
out_ready  in  1  consumer accepts product
product  out  prod_width  signed result
busy  out  1  high in RUN or DONE

Behaviour:
Interface (already decided):
- One clock, named clock.
- reset is synchronous and active-high, sampled on the rising edge of clock.

Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, product=0, all internal registers 0.

States:
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at an edge, latch:
    - neg = multiplicand sign bit
    - mag = |multiplicand| as an unsigned mcand_width value; -2^(mcand_width-1) maps to 2^(mcand_width-1) with no overflow
    - mplier_reg = multiplier
    - addend_reg = addend
    - acc = 0, count = 0
  - Go to RUN.
- RUN (in_ready=0, busy=1). Each edge performs one step:
  - if mplier_reg[0]: acc += mag_shifted (acc is prod_width unsigned)
  - mag_shifted <<= 1; mplier_reg >>= 1; count++
  - Exactly mplier_width steps, no early termination, even when multiplier is 0.
  - On the edge completing step mplier_width-1:
    - product <= (neg ? -acc : acc) + sign-extended addend_reg
    - out_valid <= 1; go to DONE.
- DONE:
  - out_valid=1, in_ready=0.
  - product is held stable while out_ready=0, for an unbounded number of cycles.
  - On out_valid&&out_ready: out_valid <= 0; go to IDLE. product keeps its last value.

Latency and throughput:
- out_valid rises mplier_width cycles after the accept edge.
- Next accept is possible at the earliest one cycle after the output handshake.
- Issue interval is at least mplier_width+2 cycles.

Width and overflow:
- |a*b + c| stays within the prod_width signed range for all inputs, so no saturation or overflow flag exists.
- Extremes:
  - -2^(m-1)*(2^n-1) - 2^(m-1) = -2^(m+n-1), exactly representable.
  - (2^(m-1)-1)*(2^n-1) + (2^(m-1)-1) < 2^(m+n-1).
- Negation and addition are done modulo 2^prod_width.

Boundary conditions:
- in_valid while busy: ignored; operands are not captured.
- Input changes during RUN: no effect.
- reset during RUN or DONE: on the next edge return to IDLE with out_valid=0 and product=0; the partial result is discarded.
- reset and in_valid in the same cycle: reset wins, nothing is captured.
- multiplier=0: product = sext(addend) after the full mplier_width cycles.
- multiplicand=0 with negative addend: product = sext(addend).

Decomposition:
- Shared package/header holds:
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2; encoding 3 is unreachable and recovers to IDLE
  - a function for sign extension of addend to prod_width
- No sub-module. The datapath (acc, shift registers, counter, final negate/add) and the FSM live in one module. The counter width is clog2(mplier_width+1).

Test Plan:
- Divider round-trip: multiplicand=33, multiplier=3, addend=1 -> product=100 (0x000064); out_valid exactly 8 cycles after the accept edge.
- Signed: multiplicand=-17 (0xFFEF), multiplier=1, addend=0 -> product=-17 (0xFFFFEF). Also multiplicand=-17, multiplier=2, addend=-1 -> -35 (0xFFFFDD).
- Extremes:
  - multiplicand=-32768, multiplier=255, addend=-32768 -> 0x800000.
  - multiplicand=32767, multiplier=255, addend=32767 -> 0x7FFF00.
- Back-pressure and ignored input:
  - Hold out_ready=0 for 5 cycles after out_valid -> product and out_valid are held stable, in_ready=0.
  - in_valid pulsed with new operands during this window -> not captured.
  - out_ready=1 -> IDLE next cycle, and the new accept produces only its own result.
- Reset mid-operation:
  - Assert reset 3 cycles into RUN -> next edge out_valid=0, product=0, in_ready=1.
  - A following operation 0 * 200 + 5 -> product=5.
- Random soak: 1000 random operand sets with random out_ready stalls. Compare each product against a*b+c in a reference model; no dropped or duplicated results.
